// File: rtl/display_writer.sv
// -----------------------------------------------------------------------------
// display_writer
//
// Front end for Display_Interface. It converts an unsigned binary value to
// eight BCD digits using sequential double dabble (shift-add-3). It then writes
// the digits into the display RAM one per clock, from the most significant
// digit (address 7) down to address 0. Leading zeros can be blanked, and one
// decimal point can be lit.
//
// Ports
//   clk       system clock, rising-edge active
//   rst       synchronous reset, active high
//   start     request strobe, accepted only while idle
//   value     unsigned binary value to display (WIDTH bits), latched on accept
//   dp_pos    digit index 0..7 whose decimal point is lit; 8..15 = no DP
//   blank_lz  1 = blank leading zeros
//   busy      high from the cycle after accept through the last write cycle
//   done      one-cycle pulse in the cycle after the last write
//   W         RAM write enable
//   WADD      RAM write address (digit index, 0 = least significant)
//   DIN       RAM write data {enable, hex[3:0], dp_n}
//
// All outputs are registers. Their next values are computed together with the
// next FSM state, so each write appears in the same cycle the FSM sits on that
// digit index.
// -----------------------------------------------------------------------------
module display_writer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] value,
    input  logic [3:0]       dp_pos,
    input  logic             blank_lz,
    output logic             busy,
    output logic             done,
    output logic             W,
    output logic [2:0]       WADD,
    output logic [5:0]       DIN
);

    localparam int             CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        WRITE
    } state_t;

    state_t           state, state_next;
    logic [31:0]      bcd, bcd_next;
    logic [WIDTH-1:0] bin, bin_next;
    logic [CW-1:0]    cnt, cnt_next;
    logic [2:0]       idx, idx_next;
    logic             lz, lz_next;
    logic [3:0]       dp_q, dp_next;
    logic             blz_q, blz_next;

    logic             busy_next, done_next, w_next;
    logic [2:0]       wadd_next;
    logic [5:0]       din_next;

    // Digit being written this cycle and the leading-zero state that applies to it.
    logic             write_now;
    logic [2:0]       wr_idx;
    logic             lz_cur;
    logic [3:0]       wr_nib;
    logic             wr_en, wr_dp_n, right_of_dp_ok;
    logic [31:0]      bcd_adj;

    // Add 3 to every BCD nibble of 5 or more, so that the next left shift carries correctly.
    function automatic logic [31:0] dabble_adjust(input logic [31:0] b);
        logic [31:0] r;
        r = b;
        for (int i = 0; i < 8; i++) begin
            if (r[4*i +: 4] >= 4'd5)
                r[4*i +: 4] = r[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

    // NOTE: every signal written here gets a default first; a path that leaves one
    // unassigned would infer a latch.
    always_comb begin
        state_next = state;
        bcd_next   = bcd;
        bin_next   = bin;
        cnt_next   = cnt;
        idx_next   = idx;
        lz_next    = lz;
        dp_next    = dp_q;
        blz_next   = blz_q;
        done_next  = 1'b0;
        w_next     = 1'b0;
        wadd_next  = WADD;
        din_next   = DIN;
        write_now  = 1'b0;
        wr_idx     = idx;
        lz_cur     = lz;
        bcd_adj    = dabble_adjust(bcd);

        case (state)
            IDLE: begin
                if (start) begin
                    state_next = CONVERT;
                    bcd_next   = '0;
                    bin_next   = value;
                    cnt_next   = '0;
                    dp_next    = dp_pos;
                    blz_next   = blank_lz;
                end
            end

            CONVERT: begin
                if (cnt == CNT_LAST) begin
                    // All bits have been shifted in. Emit digit 7 now, with the leading-zero run freshly started.
                    state_next = WRITE;
                    idx_next   = 3'd7;
                    wr_idx     = 3'd7;
                    lz_cur     = 1'b1;
                    write_now  = 1'b1;
                end else begin
                    {bcd_next, bin_next} = {bcd_adj[30:0], bin, 1'b0};
                    cnt_next             = cnt + 1'b1;
                end
            end

            WRITE: begin
                if (idx == 3'd0) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end else begin
                    idx_next  = idx - 1'b1;
                    wr_idx    = idx - 1'b1;
                    write_now = 1'b1;
                end
            end

            default: state_next = IDLE;
        endcase

        wr_nib  = bcd[{wr_idx, 2'b00} +: 4];
        wr_dp_n = ({1'b0, wr_idx} != dp_q);
        // With no DP selected (dp_pos >= 8), every digit except 0 may be blanked.
        // Otherwise only digits left of the DP may be blanked.
        right_of_dp_ok = dp_q[3] || ({1'b0, wr_idx} > dp_q);
        wr_en   = !(blz_q && lz_cur && (wr_nib == 4'd0) &&
                    (wr_idx != 3'd0) && right_of_dp_ok);

        if (write_now) begin
            w_next    = 1'b1;
            wadd_next = wr_idx;
            din_next  = {wr_en, wr_nib, wr_dp_n};
            lz_next   = lz_cur && (wr_nib == 4'd0);
        end

        busy_next = (state_next != IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments, so every register in this
    // block sees the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            bcd   <= '0;
            bin   <= '0;
            cnt   <= '0;
            idx   <= '0;
            lz    <= 1'b0;
            dp_q  <= '0;
            blz_q <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            W     <= 1'b0;
            WADD  <= '0;
            DIN   <= '0;
        end else begin
            state <= state_next;
            bcd   <= bcd_next;
            bin   <= bin_next;
            cnt   <= cnt_next;
            idx   <= idx_next;
            lz    <= lz_next;
            dp_q  <= dp_next;
            blz_q <= blz_next;
            busy  <= busy_next;
            done  <= done_next;
            W     <= w_next;
            WADD  <= wadd_next;
            DIN   <= din_next;
        end
    end

endmodule

// File: tb/tb_display_writer.sv
// -----------------------------------------------------------------------------
// tb_display_writer
//
// Directed bench for display_writer with WIDTH=16. Each scenario captures
// per-cycle output history, indexed by n = edges after the edge that samples
// start. It then compares that history against hand-computed digit frames.
// Writes are expected at n = 17..24 and done at n = 25.
// -----------------------------------------------------------------------------
module tb_display_writer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] value;
    logic [3:0]  dp_pos;
    logic        blank_lz;
    logic        busy, done, W;
    logic [2:0]  WADD;
    logic [5:0]  DIN;

    int checks   = 0;
    int failures = 0;

    logic        w_h    [64];
    logic [2:0]  wadd_h [64];
    logic [5:0]  din_h  [64];
    logic        busy_h [64];
    logic        done_h [64];

    always #5 clk = ~clk;

    display_writer #(.WIDTH(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .value    (value),
        .dp_pos   (dp_pos),
        .blank_lz (blank_lz),
        .busy     (busy),
        .done     (done),
        .W        (W),
        .WADD     (WADD),
        .DIN      (DIN)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [5:0] pk(input logic en, input logic [3:0] hex, input logic dpn);
        return {en, hex, dpn};
    endfunction

    // Issue one request, then record ncyc cycles of outputs. Optionally re-pulse
    // start (with a different value) at sa1/sa2, or assert rst at rst_at.
    task automatic capture(input logic [15:0] v, input logic [3:0] dp, input logic bl,
                           input int sa1, input int sa2, input int rst_at, input int ncyc);
        value    = v;
        dp_pos   = dp;
        blank_lz = bl;
        start    = 1'b1;
        tick();
        start = 1'b0;
        for (int n = 0; n < ncyc; n++) begin
            w_h[n]    = W;
            wadd_h[n] = WADD;
            din_h[n]  = DIN;
            busy_h[n] = busy;
            done_h[n] = done;
            start = (n == sa1) || (n == sa2);
            if (start) value = ~v;
            rst = (n == rst_at);
            tick();
        end
        start = 1'b0;
        rst   = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; value = '0; dp_pos = 4'd8; blank_lz = 1'b0;
        tick();
        tick();
        checks++;
        if ({busy, done, W, WADD, DIN} !== 12'd0) begin
            failures++;
            $display("FAIL reset: busy=%b done=%b W=%b WADD=%0d DIN=%b expected all zero",
                     busy, done, W, WADD, DIN);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0 || W !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_reset: busy=%b W=%b expected 0 0", busy, W);
        end
    endtask

    task automatic test_basic_1234();
        logic [5:0] exp_d [8];
        int first_done;
        exp_d[7] = pk(0,0,1); exp_d[6] = pk(0,0,1); exp_d[5] = pk(0,0,1); exp_d[4] = pk(0,0,1);
        exp_d[3] = pk(1,1,1); exp_d[2] = pk(1,2,1); exp_d[1] = pk(1,3,1); exp_d[0] = pk(1,4,1);
        capture(16'd1234, 4'd8, 1'b1, -1, -1, -1, 30);
        checks++;
        if (busy_h[0] !== 1'b1) begin
            failures++;
            $display("FAIL busy_after_accept: busy=%b expected 1", busy_h[0]);
        end
        checks++;
        if (w_h[16] !== 1'b0) begin
            failures++;
            $display("FAIL no_early_write: W=%b at n=16 expected 0", w_h[16]);
        end
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (w_h[17+k] !== 1'b1 || wadd_h[17+k] !== 3'(7-k) || din_h[17+k] !== exp_d[7-k]) begin
                failures++;
                $display("FAIL frame_1234 k=%0d: W=%b WADD=%0d DIN=%b expected W=1 WADD=%0d DIN=%b",
                         k, w_h[17+k], wadd_h[17+k], din_h[17+k], 7-k, exp_d[7-k]);
            end
        end
        first_done = -1;
        for (int n = 0; n < 30; n++)
            if (done_h[n] === 1'b1 && first_done < 0) first_done = n;
        checks++;
        if (first_done != 25) begin
            failures++;
            $display("FAIL latency: done at n=%0d expected 25", first_done);
        end
        checks++;
        if (busy_h[24] !== 1'b1 || busy_h[25] !== 1'b0 || w_h[25] !== 1'b0 || done_h[26] !== 1'b0) begin
            failures++;
            $display("FAIL end_timing: busy24=%b busy25=%b W25=%b done26=%b expected 1 0 0 0",
                     busy_h[24], busy_h[25], w_h[25], done_h[26]);
        end
    endtask

    task automatic test_zero();
        capture(16'd0, 4'd8, 1'b1, -1, -1, -1, 28);
        for (int k = 0; k < 8; k++) begin
            logic [5:0] e;
            e = (k == 7) ? pk(1,0,1) : pk(0,0,1);
            checks++;
            if (w_h[17+k] !== 1'b1 || wadd_h[17+k] !== 3'(7-k) || din_h[17+k] !== e) begin
                failures++;
                $display("FAIL frame_zero k=%0d: W=%b WADD=%0d DIN=%b expected W=1 WADD=%0d DIN=%b",
                         k, w_h[17+k], wadd_h[17+k], din_h[17+k], 7-k, e);
            end
        end
    endtask

    task automatic test_dp();
        logic [5:0] exp_d [8];
        for (int i = 3; i < 8; i++) exp_d[i] = pk(0,0,1);
        exp_d[2] = pk(1,0,0); exp_d[1] = pk(1,0,1); exp_d[0] = pk(1,5,1);
        capture(16'd5, 4'd2, 1'b1, -1, -1, -1, 28);
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (w_h[17+k] !== 1'b1 || wadd_h[17+k] !== 3'(7-k) || din_h[17+k] !== exp_d[7-k]) begin
                failures++;
                $display("FAIL frame_dp k=%0d: W=%b WADD=%0d DIN=%b expected W=1 WADD=%0d DIN=%b",
                         k, w_h[17+k], wadd_h[17+k], din_h[17+k], 7-k, exp_d[7-k]);
            end
        end
    endtask

    task automatic test_max_no_blank();
        logic [5:0] exp_d [8];
        int wcount;
        exp_d[7] = pk(1,0,1); exp_d[6] = pk(1,0,1); exp_d[5] = pk(1,0,1); exp_d[4] = pk(1,6,1);
        exp_d[3] = pk(1,5,1); exp_d[2] = pk(1,5,1); exp_d[1] = pk(1,3,1); exp_d[0] = pk(1,5,1);
        capture(16'd65535, 4'd8, 1'b0, -1, -1, -1, 30);
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (w_h[17+k] !== 1'b1 || wadd_h[17+k] !== 3'(7-k) || din_h[17+k] !== exp_d[7-k]) begin
                failures++;
                $display("FAIL frame_65535 k=%0d: W=%b WADD=%0d DIN=%b expected W=1 WADD=%0d DIN=%b",
                         k, w_h[17+k], wadd_h[17+k], din_h[17+k], 7-k, exp_d[7-k]);
            end
        end
        wcount = 0;
        for (int n = 0; n < 30; n++) if (w_h[n] === 1'b1) wcount++;
        checks++;
        if (wcount != 8) begin
            failures++;
            $display("FAIL write_count_65535: got %0d expected 8", wcount);
        end
    endtask

    task automatic test_start_ignored();
        logic [5:0] exp_d [8];
        int dcount;
        exp_d[7] = pk(0,0,1); exp_d[6] = pk(0,0,1); exp_d[5] = pk(0,0,1); exp_d[4] = pk(0,0,1);
        exp_d[3] = pk(1,1,1); exp_d[2] = pk(1,2,1); exp_d[1] = pk(1,3,1); exp_d[0] = pk(1,4,1);
        capture(16'd1234, 4'd8, 1'b1, 5, 20, -1, 45);
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (w_h[17+k] !== 1'b1 || wadd_h[17+k] !== 3'(7-k) || din_h[17+k] !== exp_d[7-k]) begin
                failures++;
                $display("FAIL frame_ignored_start k=%0d: W=%b WADD=%0d DIN=%b expected W=1 WADD=%0d DIN=%b",
                         k, w_h[17+k], wadd_h[17+k], din_h[17+k], 7-k, exp_d[7-k]);
            end
        end
        dcount = 0;
        for (int n = 0; n < 45; n++) if (done_h[n] === 1'b1) dcount++;
        checks++;
        if (dcount != 1 || done_h[25] !== 1'b1 || busy_h[30] !== 1'b0) begin
            failures++;
            $display("FAIL single_done: pulses=%0d done25=%b busy30=%b expected 1 1 0",
                     dcount, done_h[25], busy_h[30]);
        end
    endtask

    task automatic test_back_to_back();
        int dcount, wcount;
        capture(16'd42, 4'd8, 1'b0, 25, -1, -1, 56);
        checks++;
        if (busy_h[26] !== 1'b1 || done_h[25] !== 1'b1) begin
            failures++;
            $display("FAIL start_in_done_cycle: done25=%b busy26=%b expected 1 1",
                     done_h[25], busy_h[26]);
        end
        dcount = 0;
        wcount = 0;
        for (int n = 0; n < 56; n++) begin
            if (done_h[n] === 1'b1) dcount++;
            if (w_h[n] === 1'b1) wcount++;
        end
        checks++;
        if (dcount != 2 || done_h[51] !== 1'b1 || wcount != 16) begin
            failures++;
            $display("FAIL back_to_back: dones=%0d done51=%b writes=%0d expected 2 1 16",
                     dcount, done_h[51], wcount);
        end
    endtask

    task automatic test_reset_mid_write();
        int dcount, wcount;
        capture(16'd1234, 4'd8, 1'b1, -1, -1, 19, 30);
        checks++;
        if (w_h[19] !== 1'b1 || wadd_h[19] !== 3'd5) begin
            failures++;
            $display("FAIL third_write: W=%b WADD=%0d expected 1 5", w_h[19], wadd_h[19]);
        end
        checks++;
        if (w_h[20] !== 1'b0 || busy_h[20] !== 1'b0 || din_h[20] !== 6'd0 || wadd_h[20] !== 3'd0) begin
            failures++;
            $display("FAIL after_mid_reset: W=%b busy=%b DIN=%b WADD=%0d expected 0 0 000000 0",
                     w_h[20], busy_h[20], din_h[20], wadd_h[20]);
        end
        dcount = 0;
        wcount = 0;
        for (int n = 20; n < 30; n++) begin
            if (done_h[n] === 1'b1) dcount++;
            if (w_h[n] === 1'b1) wcount++;
        end
        checks++;
        if (dcount != 0 || wcount != 0) begin
            failures++;
            $display("FAIL aborted_frame: dones=%0d writes=%0d expected 0 0", dcount, wcount);
        end
        capture(16'd9876, 4'd8, 1'b1, -1, -1, -1, 30);
        wcount = 0;
        for (int n = 0; n < 30; n++) if (w_h[n] === 1'b1) wcount++;
        checks++;
        if (wcount != 8 || done_h[25] !== 1'b1 || din_h[24] !== pk(1,6,1) || din_h[17] !== pk(0,0,1)) begin
            failures++;
            $display("FAIL fresh_after_reset: writes=%0d done25=%b DIN24=%b DIN17=%b expected 8 1 %b %b",
                     wcount, done_h[25], din_h[24], din_h[17], pk(1,6,1), pk(0,0,1));
        end
    endtask

    initial begin
        test_reset();
        test_basic_1234();
        test_zero();
        test_dp();
        test_max_no_blank();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid_write();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
